// File: rtl/block_counter4bit_down.sv
// Prescaled down counter with parallel load and two end modes (wrap to max or halt at 0).
// All outputs are registered. The prescaler divides clk_50M down to one count tick per DIV cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | prescaler advances while En=1; each tick decrements Output
// DONE  | halted at 0 (halt mode); prescaler parked at 0; waits for Load/Reset
module block_counter4bit_down #(
   parameter int WIDTH = 4,
   parameter int DIV   = 50_000_000
) (
   input  logic             clk_50M,
   input  logic             Reset,
   input  logic             En,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_val,
   input  logic             Wrap,
   output logic [WIDTH-1:0] Output,
   output logic             Tick,
   output logic             Borrow,
   output logic             Done
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick_d, borrow_d, done_d;
   logic             tick_due;

   assign tick_due = (presc_q == PRESC_LAST);

   always_ff @(posedge clk_50M) begin
      if (!Reset) begin
         state_q <= RUN;
         presc_q <= '0;
         count_q <= CNT_MAX;
         Tick    <= 1'b0;
         Borrow  <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         Tick    <= tick_d;
         Borrow  <= borrow_d;
         Done    <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      count_d  = count_q;
      tick_d   = 1'b0;
      borrow_d = 1'b0;

      if (Load) begin
         // Load wins over a tick that falls due in the same cycle.
         count_d = Load_val;
         presc_d = '0;
         state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (En) begin
                  if (tick_due) begin
                     presc_d = '0;
                     tick_d  = 1'b1;
                     if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                        if ((count_d == '0) && !Wrap) begin
                           state_d = DONE;
                        end
                     end else if (Wrap) begin
                        count_d  = CNT_MAX;
                        borrow_d = 1'b1;
                     end else begin
                        state_d = DONE;
                     end
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
            end
            DONE: begin
               presc_d = '0;
               count_d = '0;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      done_d = (state_d == DONE);
   end

   assign Output = count_q;

endmodule
